// File: rtl/pulse_train_generator.sv
// Pulse train generator: emits `count` pulses of high_len cycles high followed by
// low_len cycles low, then a one-cycle done strobe. Command fields are latched on accept.
module pulse_train_generator #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] high_len,
    input  logic [WIDTH-1:0] low_len,
    input  logic [WIDTH-1:0] count,
    input  logic             abort,
    output logic             data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] high_len_r;
    logic [WIDTH-1:0] low_len_r;
    logic [WIDTH-1:0] phase_cnt_r;
    logic [WIDTH-1:0] high_eff_s;
    logic [WIDTH-1:0] low_eff_s;

    // Zero-length phases behave as one-cycle phases.
    always_comb begin
        high_eff_s = high_len;
        low_eff_s  = low_len;
        if (high_len == ZERO) begin
            high_eff_s = ONE;
        end else begin
            high_eff_s = high_len;
        end
        if (low_len == ZERO) begin
            low_eff_s = ONE;
        end else begin
            low_eff_s = low_len;
        end
    end

    // Main FSM with registered outputs; phase_cnt_r holds cycles left in the phase minus one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            high_len_r  <= ONE;
            low_len_r   <= ONE;
            phase_cnt_r <= ZERO;
            remaining   <= ZERO;
            data        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid) begin
                        high_len_r <= high_eff_s;
                        low_len_r  <= low_eff_s;
                        cmd_ready  <= 1'b0;
                        if (count == ZERO) begin
                            state_r     <= DONE;
                            data        <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            remaining   <= ZERO;
                            phase_cnt_r <= ZERO;
                        end else begin
                            state_r     <= HIGH;
                            data        <= 1'b1;
                            busy        <= 1'b1;
                            remaining   <= count - ONE;
                            phase_cnt_r <= high_eff_s - ONE;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                        data      <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                HIGH: begin
                    if (abort) begin
                        state_r     <= IDLE;
                        data        <= 1'b0;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        remaining   <= ZERO;
                        phase_cnt_r <= ZERO;
                    end else if (phase_cnt_r == ZERO) begin
                        state_r     <= LOW;
                        data        <= 1'b0;
                        phase_cnt_r <= low_len_r - ONE;
                    end else begin
                        phase_cnt_r <= phase_cnt_r - ONE;
                    end
                end
                LOW: begin
                    if (abort) begin
                        state_r     <= IDLE;
                        data        <= 1'b0;
                        busy        <= 1'b0;
                        cmd_ready   <= 1'b1;
                        remaining   <= ZERO;
                        phase_cnt_r <= ZERO;
                    end else if (phase_cnt_r == ZERO) begin
                        if (remaining != ZERO) begin
                            state_r     <= HIGH;
                            data        <= 1'b1;
                            remaining   <= remaining - ONE;
                            phase_cnt_r <= high_len_r - ONE;
                        end else begin
                            state_r <= DONE;
                            data    <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        phase_cnt_r <= phase_cnt_r - ONE;
                    end
                end
                DONE: begin
                    state_r   <= IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    data      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    data        <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    cmd_ready   <= 1'b1;
                    remaining   <= ZERO;
                    phase_cnt_r <= ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator: hand-computed waveforms checked with
// immediate assertions one cycle at a time.
module tb_pulse_train_generator;

    localparam int WIDTH = 8;

    logic             clock;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] high_len;
    logic [WIDTH-1:0] low_len;
    logic [WIDTH-1:0] count;
    logic             abort;
    logic             data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] remaining;

    int checks = 0;
    int errors = 0;

    pulse_train_generator #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .high_len  (high_len),
        .low_len   (low_len),
        .count     (count),
        .abort     (abort),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Checks data over n cycles against pat (MSB first); the first cycle is already current.
    task automatic expect_seq(input string tag, input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            chk(tag, {31'd0, data}, {31'd0, pat[n-1-i]});
        end
    endtask

    task automatic drive_cmd(input logic [7:0] h, input logic [7:0] l, input logic [7:0] c);
        cmd_valid = 1'b1;
        high_len  = h;
        low_len   = l;
        count     = c;
    endtask

    int prev_d;
    int rises;
    int r0, r1, r2;
    int done_seen;
    int hi_cnt;
    logic [9:0] pat10;

    initial begin
        reset_n   = 1'b1;
        cmd_valid = 1'b0;
        high_len  = 8'd0;
        low_len   = 8'd0;
        count     = 8'd0;
        abort     = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_data", {31'd0, data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rem", {24'd0, remaining}, 32'd0);
        step();
        step();
        reset_n = 1'b1;

        // 3/2/2 train accepted on the first edge after release; inputs scrambled after accept.
        drive_cmd(8'd3, 8'd2, 8'd2);
        step();
        cmd_valid = 1'b0;
        high_len  = 8'd1;
        low_len   = 8'd7;
        count     = 8'd9;
        pat10 = 10'b1110011100;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            chk("t1_data", {31'd0, data}, {31'd0, pat10[9-i]});
            chk("t1_busy", {31'd0, busy}, 32'd1);
            chk("t1_rem", {24'd0, remaining}, (i < 5) ? 32'd1 : 32'd0);
        end
        step();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_done_busy", {31'd0, busy}, 32'd0);
        chk("t1_done_data", {31'd0, data}, 32'd0);
        chk("t1_done_ready", {31'd0, cmd_ready}, 32'd0);
        step();
        chk("t1_idle_done", {31'd0, done}, 32'd0);
        chk("t1_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // count=0 accepted on the first IDLE cycle after DONE.
        drive_cmd(8'd4, 8'd4, 8'd0);
        step();
        cmd_valid = 1'b0;
        chk("c0_done", {31'd0, done}, 32'd1);
        chk("c0_busy", {31'd0, busy}, 32'd0);
        chk("c0_data", {31'd0, data}, 32'd0);
        step();
        chk("c0_idle_done", {31'd0, done}, 32'd0);
        chk("c0_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Zero lengths act as one; abort alongside cmd_valid in IDLE still accepts.
        drive_cmd(8'd0, 8'd0, 8'd3);
        abort = 1'b1;
        step();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("z_busy", {31'd0, busy}, 32'd1);
        expect_seq("z_data", 16'b101010, 6);
        step();
        chk("z_done", {31'd0, done}, 32'd1);
        step();

        // Abort in the second high phase of a 2/1/4 train.
        drive_cmd(8'd2, 8'd1, 8'd4);
        step();
        cmd_valid = 1'b0;
        expect_seq("ab_data", 16'b1101, 4);
        chk("ab_rem_before", {24'd0, remaining}, 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_data_after", {31'd0, data}, 32'd0);
        chk("ab_busy", {31'd0, busy}, 32'd0);
        chk("ab_ready", {31'd0, cmd_ready}, 32'd1);
        chk("ab_rem", {24'd0, remaining}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("ab_no_done", {31'd0, done}, 32'd0);
            step();
        end

        // Abort held through DONE does not cancel the done pulse.
        drive_cmd(8'd1, 8'd1, 8'd0);
        abort = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("abd_done", {31'd0, done}, 32'd1);
        step();
        abort = 1'b0;
        chk("abd_idle_done", {31'd0, done}, 32'd0);
        chk("abd_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Asynchronous reset mid-pulse, then immediate new command.
        drive_cmd(8'd5, 8'd5, 8'd2);
        step();
        cmd_valid = 1'b0;
        step();
        chk("ar_pre_data", {31'd0, data}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("ar_data", {31'd0, data}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_ready", {31'd0, cmd_ready}, 32'd1);
        chk("ar_rem", {24'd0, remaining}, 32'd0);
        #1 reset_n = 1'b1;
        drive_cmd(8'd1, 8'd1, 8'd1);
        step();
        cmd_valid = 1'b0;
        chk("ar_new_data", {31'd0, data}, 32'd1);
        chk("ar_new_busy", {31'd0, busy}, 32'd1);
        step();
        chk("ar_new_low", {31'd0, data}, 32'd0);
        step();
        chk("ar_new_done", {31'd0, done}, 32'd1);
        step();

        // Rising-edge detection on data for a 2/5/3 train.
        drive_cmd(8'd2, 8'd5, 8'd3);
        step();
        cmd_valid = 1'b0;
        prev_d    = 0;
        rises     = 0;
        r0 = -1; r1 = -1; r2 = -1;
        done_seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (data === 1'b1 && prev_d == 0) begin
                if (rises == 0) r0 = cyc;
                else if (rises == 1) r1 = cyc;
                else r2 = cyc;
                rises++;
            end
            prev_d = (data === 1'b1) ? 1 : 0;
            if (done === 1'b1) begin
                done_seen = 1;
                break;
            end
            step();
        end
        chk("ed_rises", rises, 32'd3);
        chk("ed_gap1", r1 - r0, 32'd7);
        chk("ed_gap2", r2 - r1, 32'd7);
        chk("ed_done", done_seen, 32'd1);
        step();

        // Maximum high length gives exactly 255 high cycles.
        drive_cmd(8'd255, 8'd1, 8'd1);
        step();
        cmd_valid = 1'b0;
        hi_cnt = 0;
        while (data === 1'b1 && hi_cnt < 300) begin
            hi_cnt++;
            step();
        end
        chk("max_high", hi_cnt, 32'd255);
        chk("max_low", {31'd0, data}, 32'd0);
        step();
        chk("max_done", {31'd0, done}, 32'd1);
        step();
        chk("max_idle", {31'd0, cmd_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_train_generator.md
PULSE_TRAIN_GENERATOR -- requirements
Module: pulse_train_generator

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of the length and count fields.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present on high_len/low_len/count.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 high_len  input  WIDTH  cycles data is held high per pulse.
REQ-007 low_len  input  WIDTH  cycles data is held low after each pulse.
REQ-008 count  input  WIDTH  number of pulses to emit.
REQ-009 abort  input  1  synchronous cancel of the running train.
REQ-010 data  output  1  generated waveform; feeds edge-detection logic downstream.
REQ-011 busy  output  1  train in progress.
REQ-012 done  output  1  one-cycle pulse when a train completes normally.
REQ-013 remaining  output  WIDTH  pulses not yet started.

Function
REQ-014 The block SHALL implement the FSM states IDLE, HIGH, LOW and DONE.
REQ-015 All outputs SHALL be registered.
REQ-016 cmd_ready SHALL be 1 in IDLE only.
REQ-017 busy SHALL be 1 in HIGH and LOW only.
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-019 On acceptance, high_len, low_len and count SHALL be latched; later input changes SHALL have no effect on the running train.
REQ-020 A high_len or low_len of 0 SHALL be treated as 1.
REQ-021 Accept with count>=1 SHALL move to HIGH with data=1 in the cycle after the accept edge; remaining SHALL load count-1.
REQ-022 HIGH SHALL last exactly high_len cycles, then move to LOW with data=0.
REQ-023 LOW SHALL last exactly low_len cycles.
REQ-024 At the end of LOW, if remaining>0 the FSM SHALL return to HIGH and decrement remaining; otherwise it SHALL enter DONE.
REQ-025 The pulse period SHALL be high_len+low_len cycles, with no extra gap cycles.
REQ-026 Accept with count=0 SHALL go directly to DONE with data held 0.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-028 A new command SHALL be acceptable on the first IDLE cycle after DONE.
REQ-029 abort=1 in HIGH or LOW SHALL, at the next edge, force IDLE, data=0 and remaining=0, with no done pulse.
REQ-030 abort in IDLE or DONE SHALL be ignored; DONE still completes.
REQ-031 If abort and cmd_valid are both 1 in IDLE, the command SHALL be accepted.
REQ-032 The phase counter SHALL be WIDTH bits and SHALL NOT wrap: a length of 2^WIDTH-1 gives exactly that many cycles.

Reset
REQ-033 reset_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, data=0, busy=0, done=0, remaining=0, cmd_ready=1, and clear the internal counters.
REQ-034 Reset asserted mid-train SHALL discard the train; after release the block SHALL wait in IDLE for a new command.
REQ-035 The first edge after reset_n rises SHALL be able to accept a command.

Verification
REQ-036 Scenario: high_len=3, low_len=2, count=2 -> data 1,1,1,0,0,1,1,1,0,0 starting the cycle after accept, then done=1 for one cycle and remaining stepping 1 then 0.
REQ-037 Scenario: count=0 -> no data high, done=1 in the cycle after accept, busy stays 0.
REQ-038 Scenario: high_len=0, low_len=0, count=3 -> data alternates 1,0,1,0,1,0, then done.
REQ-039 Scenario: abort raised during the 2nd high phase of a count=4 train -> data=0 and IDLE on the next edge, done never asserted, cmd_ready=1.
REQ-040 Scenario: reset_n dropped between edges mid-pulse -> data=0 before the next rising edge; a new command is accepted right after release.
REQ-041 Scenario: data looped into the existing edge detector with high_len=2, low_len=5, count=3 -> exactly 3 edge_detect pulses, one per rising edge of data, spaced 7 cycles apart.
